// File: rtl/param_sync_fifo.sv
// param_sync_fifo
//   Parametrised single-clock FIFO with occupancy count, almost-full and
//   almost-empty thresholds, overflow/underflow pulses and a read-valid strobe.
//
//   Compile-time option: define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through
//   reads. Otherwise reads are registered with one cycle of latency.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   w_en          write request
//   r_en          read request (FWFT: pop of the presented word)
//   data_in       write data
//   data_out      read data
//   rd_valid      data_out holds valid read data
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      one-cycle pulse after a rejected write
//   underflow     one-cycle pulse after a rejected read
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic                    r_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  // Flags come from the registered count only, so no request input reaches them.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    rd_acc      = r_en && !empty;
    // A write into a full FIFO is fine when a read frees the slot in the same edge.
    wr_acc      = w_en && (!full || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = w_en && !wr_acc;
    underflow_d = r_en && !rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + PW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // Head word is presented directly; zero while empty keeps the reset view clean.
  assign rd_valid = !empty;
  assign data_out = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign data_out = data_q;
  assign rd_valid = rd_valid_q;
`endif

  // The extra pointer bit makes the distance between pointers equal to the occupancy.
  assert property (@(posedge clk) disable iff (rst) count_q == PW'(wr_ptr_q - rd_ptr_q));

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  int n_chk = 0;
  int n_err = 0;

  param_sync_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout want finish");
    $fatal(1);
  end

  // status vector: full empty af ae ovf udf rv count[3:0]
  wire [10:0] stat = {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid, count};

  // Reference model: a queue of stored words plus the last read result.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout = '0;
  logic          m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    logic ra, wa;
    if (rs) begin
      mq.delete();
      m_dout = '0; m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < DEPTH) || ra);
      m_ovf = w && !wa;
      m_udf = r && !ra;
      m_rv  = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
    end
  endtask

  function automatic logic [10:0] exp_stat();
    int n = mq.size();
    logic rv;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    rv = (n > 0);
`else
    rv = m_rv;
`endif
    return {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, rv, 4'(n)};
  endfunction

  function automatic logic dout_care();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    return mq.size() > 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_dout();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    return (mq.size() > 0) ? mq[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
    w_en = w; r_en = r; data_in = d; rst = rs;
    model_step(w, r, d, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'hAB, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    n_chk++;
    if (stat !== 11'b01_01_000_0000) begin
      n_err++; $display("FAIL reset_stat: got %b want %b", stat, 11'b01_01_000_0000);
    end
    n_chk++;
    if (data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_dout: got %h want 00", data_out);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] wd [3];
    wd[0] = 8'h01; wd[1] = 8'h02; wd[2] = 8'h03;
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, wd[i], 1'b0);
    n_chk++;
    if (count !== 4'd3) begin
      n_err++; $display("FAIL basic_count3: got %0d want 3", count);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_chk++;
    if (stat !== exp_stat()) begin
      n_err++; $display("FAIL basic_stat: got %b want %b", stat, exp_stat());
    end
    n_chk++;
    if (count !== 4'd2 || almost_empty !== 1'b1 || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL basic_after_read: got count %0d ae %b rv %b want 2 1 1", count, almost_empty, rd_valid);
    end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    n_chk++;
    if (data_out !== 8'h01) begin
      n_err++; $display("FAIL basic_dout: got %h want 01", data_out);
    end
`endif
  endtask

  task automatic test_full_overflow();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      n_chk++;
      if (stat !== exp_stat()) begin
        n_err++; $display("FAIL fill_stat[%0d]: got %b want %b", i, stat, exp_stat());
      end
    end
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    n_chk++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      n_err++; $display("FAIL overflow_pulse: got ovf %b count %0d full %b want 1 8 1", overflow, count, full);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    n_chk++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL overflow_single: got %b want 0", overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      n_chk++;
      if (stat !== exp_stat()) begin
        n_err++; $display("FAIL drain_stat[%0d]: got %b want %b", i, stat, exp_stat());
      end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      n_chk++;
      if (data_out !== 8'(8'h10 + i)) begin
        n_err++; $display("FAIL drain_data[%0d]: got %h want %h", i, data_out, 8'(8'h10 + i));
      end
`endif
    end
  endtask

  task automatic test_full_rw();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 8'hAA, 1'b0);
      n_chk++;
      if (overflow !== 1'b0 || count !== 4'd8) begin
        n_err++; $display("FAIL fullrw_ovf[%0d]: got ovf %b count %0d want 0 8", i, overflow, count);
      end
      if (dout_care()) begin
        n_chk++;
        if (data_out !== exp_dout()) begin
          n_err++; $display("FAIL fullrw_data[%0d]: got %h want %h", i, data_out, exp_dout());
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      n_chk++;
      if (data_out !== 8'hAA) begin
        n_err++; $display("FAIL fullrw_drain[%0d]: got %h want aa", i, data_out);
      end
`endif
    end
    n_chk++;
    if (stat !== exp_stat()) begin
      n_err++; $display("FAIL fullrw_end_stat: got %b want %b", stat, exp_stat());
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_chk++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || stat !== exp_stat()) begin
      n_err++; $display("FAIL underflow_empty: got %b want %b", stat, exp_stat());
    end
`ifndef PARAM_SYNC_FIFO_FWFT_EN
    n_chk++;
    if (data_out !== 8'h77) begin
      n_err++; $display("FAIL underflow_hold: got %h want 77", data_out);
    end
`endif
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    n_chk++;
    if (underflow !== 1'b1 || count !== 4'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL underflow_rw: got udf %b count %0d empty %b want 1 1 0", underflow, count, empty);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    if (dout_care() || 1'b1) begin
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      n_chk++;
      if (data_out !== 8'h55) begin
        n_err++; $display("FAIL underflow_rw_data: got %h want 55", data_out);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h99, 1'b1);
    n_chk++;
    if (stat !== 11'b01_01_000_0000 || data_out !== 8'h00) begin
      n_err++; $display("FAIL midreset: got %b/%h want 01010000000/00", stat, data_out);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_chk++;
    if (underflow !== 1'b1 || stat !== exp_stat()) begin
      n_err++; $display("FAIL midreset_udf: got %b want %b", stat, exp_stat());
    end
  endtask

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    n_chk++;
    if (data_out !== 8'h3C || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL fwft_show: got %h rv %b want 3c 1", data_out, rd_valid);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    n_chk++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL fwft_pop: got empty %b rv %b want 1 0", empty, rd_valid);
    end
  endtask
`endif

  task automatic test_random();
    logic w, r, rs;
    int pw;
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 600; i++) begin
      // alternate write-heavy and read-heavy phases so both ends are reached
      pw = ((i / 40) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < (105 - pw));
      rs = ($urandom_range(0, 199) == 0);
      cycle(w, r, 8'($urandom), rs);
      n_chk++;
      if (stat !== exp_stat()) begin
        n_err++; $display("FAIL rand_stat[%0d]: got %b want %b", i, stat, exp_stat());
      end
      if (dout_care()) begin
        n_chk++;
        if (data_out !== exp_dout()) begin
          n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, data_out, exp_dout());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_full_rw();
    test_underflow();
    test_reset_mid();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
